// File: rtl/red_writeback_stage.sv
// red_writeback_stage: two-entry FIFO between the 16-bit reduction unit and the
// register-file write port. It sign-extends each 7-bit reduction sum to 16 bits
// and counts completed writebacks, saturating at 255.
//
// Optional feature: define RED_WB_BYPASS_EN to let an entry that arrives while
// the FIFO is empty drive the writeback port in the same cycle.
//
// Ports:
//   clk       single clock; all state updates on the rising edge
//   rst       synchronous active-high reset
//   in_valid  reduction result presented this cycle
//   in_rd     signed 7-bit reduction sum
//   in_dst    destination register index
//   in_ready  stage can accept an entry this cycle
//   flush     discard all buffered results
//   wb_valid  writeback request to the register-file write port
//   wb_ready  write port grants the request this cycle
//   wb_reg    destination index of the head entry (0 when idle)
//   wb_data   sign-extended head result (0 when idle)
//   wb_count  saturating count of completed writebacks
module red_writeback_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [6:0]  in_rd,
  input  logic [3:0]  in_dst,
  output logic        in_ready,
  input  logic        flush,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [3:0]  wb_reg,
  output logic [15:0] wb_data,
  output logic [7:0]  wb_count
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e      state_q, state_d;
  // Entry layout: {rd[6:0], dst[3:0]}. head_q is always the oldest entry.
  logic [10:0] head_q, head_d;
  logic [10:0] tail_q, tail_d;
  logic [7:0]  count_q, count_d;

  logic        bypass;
  logic [10:0] in_entry;
  logic [10:0] out_entry;
  logic        push;
  logic        pop;

  assign in_entry = {in_rd, in_dst};

  always_comb begin
`ifdef RED_WB_BYPASS_EN
    bypass = (state_q == StEmpty) && in_valid && !flush && !rst;
`else
    bypass = 1'b0;
`endif
    // Outputs are forced to their reset values while rst is high.
    in_ready  = rst || (state_q != StFull);
    wb_valid  = !rst && ((state_q != StEmpty) || bypass);
    out_entry = bypass ? in_entry : head_q;
    wb_reg    = wb_valid ? out_entry[3:0] : 4'd0;
    wb_data   = wb_valid ? {{9{out_entry[10]}}, out_entry[10:4]} : 16'd0;
    wb_count  = rst ? 8'd0 : count_q;
    push      = in_valid && in_ready;
    pop       = wb_valid && wb_ready;
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    // A pop is counted even when a flush discards the rest of the buffer.
    if (pop && (count_q != 8'hFF)) begin
      count_d = count_q + 8'd1;
    end

    if (flush) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          // A bypassed entry that is granted immediately never enters the FIFO.
          if (push && !(bypass && pop)) begin
            head_d  = in_entry;
            state_d = StOne;
          end
        end
        StOne: begin
          if (push && pop) begin
            head_d = in_entry;
          end else if (push) begin
            tail_d  = in_entry;
            state_d = StFull;
          end else if (pop) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          // in_ready is low here, so only a pop can happen.
          if (pop) begin
            head_d  = tail_q;
            state_d = StOne;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEmpty;
      head_q  <= 11'd0;
      tail_q  <= 11'd0;
      count_q <= 8'd0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_red_writeback_stage.sv
// Testbench for red_writeback_stage: directed scenarios followed by random
// traffic, every cycle compared against a queue-based reference model.
module tb_red_writeback_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [6:0]  in_rd;
  logic [3:0]  in_dst;
  logic        in_ready;
  logic        flush;
  logic        wb_valid;
  logic        wb_ready;
  logic [3:0]  wb_reg;
  logic [15:0] wb_data;
  logic [7:0]  wb_count;

  always #5 clk = ~clk;

  red_writeback_stage dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_rd    (in_rd),
    .in_dst   (in_dst),
    .in_ready (in_ready),
    .flush    (flush),
    .wb_valid (wb_valid),
    .wb_ready (wb_ready),
    .wb_reg   (wb_reg),
    .wb_data  (wb_data),
    .wb_count (wb_count)
  );

  typedef struct packed {
    logic [6:0] rd;
    logic [3:0] dst;
  } ent_t;

  ent_t q[$];
  int   cnt;
  int   checks;
  int   errors;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Two's-complement value of a 7-bit sum, widened to 16 bits arithmetically.
  function automatic logic [15:0] sext(input logic [6:0] r);
    int v;
    v = int'(r);
    if (v >= 64) v = v - 128;
    return 16'(v);
  endfunction

  function automatic logic [6:0] rand_rd();
    return 7'($urandom_range(0, 120) - 64);
  endfunction

  // One clock cycle: drive, compare all outputs with the model, clock, update model.
  task automatic step(input logic v, input logic [6:0] rd, input logic [3:0] dst,
                      input logic wr, input logic fl, input logic rs);
    logic        byp;
    logic        ev;
    logic        er;
    logic        pop;
    logic        push;
    logic [3:0]  eg;
    logic [15:0] ed;
    ent_t        e;
    in_valid = v;
    in_rd    = rd;
    in_dst   = dst;
    wb_ready = wr;
    flush    = fl;
    rst      = rs;
    #2;
    byp = 1'b0;
`ifdef RED_WB_BYPASS_EN
    byp = (q.size() == 0) && v && !fl && !rs;
`endif
    er = rs || (q.size() < 2);
    ev = !rs && ((q.size() > 0) || byp);
    eg = 4'd0;
    ed = 16'd0;
    if (ev) begin
      if (q.size() > 0) begin
        eg = q[0].dst;
        ed = sext(q[0].rd);
      end else begin
        eg = dst;
        ed = sext(rd);
      end
    end
    check("in_ready", 16'(in_ready), 16'(er));
    check("wb_valid", 16'(wb_valid), 16'(ev));
    check("wb_reg", 16'(wb_reg), 16'(eg));
    check("wb_data", wb_data, ed);
    check("wb_count", 16'(wb_count), rs ? 16'd0 : 16'(cnt));
    @(posedge clk);
    #1;
    pop  = ev && wr;
    push = v && er;
    if (rs) begin
      q.delete();
      cnt = 0;
    end else begin
      if (pop && cnt < 255) cnt++;
      if (fl) begin
        q.delete();
      end else if (!(byp && pop)) begin
        if (pop) void'(q.pop_front());
        if (push) begin
          e.rd  = rd;
          e.dst = dst;
          q.push_back(e);
        end
      end
    end
  endtask

  // Quiet inputs so registered outputs can be checked against fixed values.
  task automatic peek();
    in_valid = 1'b0;
    wb_ready = 1'b0;
    flush    = 1'b0;
    rst      = 1'b0;
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cnt    = 0;

    // Reset
    step(1'b1, 7'h11, 4'd9, 1'b1, 1'b0, 1'b1);
    step(1'b0, 7'h00, 4'd0, 1'b0, 1'b0, 1'b1);
    peek();
    check("rst_wb_valid", 16'(wb_valid), 16'd0);
    check("rst_in_ready", 16'(in_ready), 16'd1);
    check("rst_wb_count", 16'(wb_count), 16'd0);

    // Single entry, rd=-1 dst=3
    step(1'b1, 7'h7F, 4'd3, 1'b1, 1'b0, 1'b0);
`ifndef RED_WB_BYPASS_EN
    peek();
    check("single_data", wb_data, 16'hFFFF);
    check("single_reg", 16'(wb_reg), 16'd3);
    step(1'b0, 7'h00, 4'd0, 1'b1, 1'b0, 1'b0);
`endif
    peek();
    check("single_count", 16'(wb_count), 16'd1);

    // Backpressure: fill, hold, then drain in order
    step(1'b1, 7'd56, 4'd1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 7'h40, 4'd2, 1'b0, 1'b0, 1'b0);
    peek();
    check("bp_in_ready", 16'(in_ready), 16'd0);
    check("bp_head", wb_data, 16'h0038);
    step(1'b1, 7'd5, 4'd5, 1'b0, 1'b0, 1'b0);
    peek();
    check("bp_hold", wb_data, 16'h0038);
    step(1'b0, 7'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    peek();
    check("bp_second", wb_data, 16'hFFC0);
    check("bp_second_reg", 16'(wb_reg), 16'd2);
    step(1'b0, 7'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    peek();
    check("bp_drained", 16'(wb_valid), 16'd0);

    // Push and pop together in ONE
    step(1'b1, 7'd5, 4'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 7'd9, 4'd4, 1'b1, 1'b0, 1'b0);
    peek();
    check("pp_data", wb_data, 16'h0009);
    check("pp_in_ready", 16'(in_ready), 16'd1);
    step(1'b1, 7'd1, 4'd1, 1'b0, 1'b0, 1'b0);
    peek();
    check("pp_full", 16'(in_ready), 16'd0);

    // Flush while FULL with a push offered
    step(1'b1, 7'd3, 4'd3, 1'b0, 1'b1, 1'b0);
    peek();
    check("flush_valid", 16'(wb_valid), 16'd0);
    check("flush_in_ready", 16'(in_ready), 16'd1);
    check("flush_count", 16'(wb_count), 16'd4);

    // Stream until the count reaches 10, fill, then reset mid-operation
    for (int i = 0; i < 50 && cnt < 10; i++) begin
      step(1'b1, rand_rd(), 4'($urandom), 1'b1, 1'b0, 1'b0);
    end
    step(1'b1, rand_rd(), 4'd6, 1'b0, 1'b0, 1'b0);
    step(1'b1, rand_rd(), 4'd7, 1'b0, 1'b0, 1'b0);
    peek();
    check("pre_rst_count", 16'(wb_count), 16'd10);
    check("pre_rst_full", 16'(in_ready), 16'd0);
    step(1'b1, rand_rd(), 4'd8, 1'b1, 1'b0, 1'b1);
    peek();
    check("mid_rst_valid", 16'(wb_valid), 16'd0);
    check("mid_rst_count", 16'(wb_count), 16'd0);

    // Saturation after more than 255 pops
    for (int i = 0; i < 300; i++) begin
      step(1'b1, rand_rd(), 4'($urandom), 1'b1, 1'b0, 1'b0);
    end
    peek();
    check("sat_count", 16'(wb_count), 16'd255);

`ifdef RED_WB_BYPASS_EN
    // Same-cycle bypass from EMPTY
    step(1'b0, 7'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    in_valid = 1'b1;
    in_rd    = 7'd4;
    in_dst   = 4'd7;
    wb_ready = 1'b1;
    flush    = 1'b0;
    rst      = 1'b0;
    #1;
    check("byp_valid", 16'(wb_valid), 16'd1);
    check("byp_data", wb_data, 16'h0004);
    step(1'b1, 7'd4, 4'd7, 1'b1, 1'b0, 1'b0);
    peek();
    check("byp_empty", 16'(wb_valid), 16'd0);
`endif

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      step(1'($urandom_range(0, 3) != 0), rand_rd(), 4'($urandom),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 63) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/red_writeback_stage.md
RED_WRITEBACK_STAGE -- requirements
Module: red_writeback_stage

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-003 SHALL have port in_valid, input, 1, reduction result presented this cycle.
REQ-004 SHALL have port in_rd, input, 7, signed reduction sum (range -64..+56) from the 16-bit reduction unit.
REQ-005 SHALL have port in_dst, input, 4, destination register index for the result.
REQ-006 SHALL have port in_ready, output, 1, stage can accept an entry this cycle.
REQ-007 SHALL have port flush, input, 1, discard all buffered results.
REQ-008 SHALL have port wb_valid, output, 1, writeback request to the register-file write port.
REQ-009 SHALL have port wb_ready, input, 1, write port grants the request this cycle.
REQ-010 SHALL have port wb_reg, output, 4, destination index of the head entry.
REQ-011 SHALL have port wb_data, output, 16, sign-extended head result.
REQ-012 SHALL have port wb_count, output, 8, number of completed writebacks, saturating.

Function
REQ-013 SHALL buffer up to 2 entries (11 bits each: 7 data plus 4 index) in FIFO order.
REQ-014 SHALL track occupancy with states EMPTY, ONE and FULL.
REQ-015 SHALL accept an entry (push) when in_valid and in_ready are both high at a rising edge.
REQ-016 SHALL complete an entry (pop) when wb_valid and wb_ready are both high at a rising edge.
REQ-017 SHALL drive in_ready = 1 in EMPTY and ONE, and in_ready = 0 in FULL, including when wb_ready is high.
REQ-018 SHALL drive wb_valid = 1 exactly when occupancy is nonzero, except as extended by REQ-031.
REQ-019 SHALL drive wb_data = {9 copies of rd[6], rd[6:0]} and wb_reg = the index of the head entry.
REQ-020 SHALL hold wb_data and wb_reg stable while wb_valid is high and wb_ready is low.
REQ-021 SHALL apply these state transitions:
- push only: EMPTY->ONE, ONE->FULL.
- pop only: FULL->ONE, ONE->EMPTY.
- push and pop together in ONE: stay in ONE; the new entry becomes the head the next cycle.
REQ-022 SHALL have a latency of 1 cycle: an entry pushed at edge N appears on wb_* after edge N, when the FIFO was empty.
REQ-023 SHALL ignore in_rd and in_dst when in_valid is low, and SHALL ignore wb_ready when wb_valid is low.
REQ-024 SHALL, when flush is high at an edge, set occupancy to EMPTY and discard any same-cycle push.
REQ-025 SHALL count a same-cycle pop into wb_count even when flush is high.
REQ-026 SHALL increment wb_count on each pop and hold it at 255 once it reaches 255.

Reset
REQ-027 SHALL, on rst high at an edge, set occupancy to EMPTY and wb_count to 0.
REQ-028 SHALL give rst priority over flush, push and pop, and SHALL cancel any in-progress entry with no writeback.
REQ-029 SHALL hold these outputs during and after reset: in_ready = 1, wb_valid = 0, wb_reg = 0, wb_data = 0, wb_count = 0.
REQ-030 SHALL drive wb_reg = 0 and wb_data = 0 whenever wb_valid is low.

Configuration
REQ-031 SHALL provide macro RED_WB_BYPASS_EN with this behaviour when defined:
- Applies when the FIFO is EMPTY, in_valid is high and flush is low.
- wb_valid, wb_reg and wb_data are driven combinationally from the input, giving 0-cycle latency.
- If wb_ready is also high, the entry completes without entering the FIFO and wb_count increments.
- If wb_ready is low, the entry is pushed normally.
REQ-032 SHALL, when RED_WB_BYPASS_EN is undefined, have no combinational path from in_* to wb_*; latency is exactly 1 cycle per REQ-022.

Verification
REQ-033 SHALL cover single entry: push in_rd=7'h7F (-1), in_dst=3 with wb_ready=1 -> next cycle wb_data=16'hFFFF, wb_reg=3; after the pop, wb_count=1.
REQ-034 SHALL cover backpressure: hold wb_ready=0 and push rd=56 dst=1, then rd=-64 dst=2 -> in_ready=0 and wb_data=16'h0038 stable; raise wb_ready -> 16'h0038 then 16'hFFC0 pop in order.
REQ-035 SHALL cover simultaneous push and pop in ONE: head rd=5 pops while rd=9 is pushed -> state stays ONE, next wb_data=16'h0009.
REQ-036 SHALL cover flush: flush=1 while FULL with in_valid=1 -> next cycle wb_valid=0, in_ready=1, wb_count unchanged.
REQ-037 SHALL cover reset mid-operation: rst=1 while FULL with wb_count=10 -> wb_valid=0, wb_count=0; and 260 pops -> wb_count=255.
REQ-038 SHALL cover bypass (RED_WB_BYPASS_EN defined): EMPTY, in_valid=1, rd=4, dst=7, wb_ready=1 -> same cycle wb_valid=1, wb_data=16'h0004; state remains EMPTY.
